// File: rtl/half_adder_bist.sv
// half_adder_bist -- built-in self-test engine for a combinational half adder.
//
// Drives the four {a,b} vectors (00, 01, 10, 11) into an external half-adder
// DUT, holds each vector for SETTLE_CYCLES cycles, samples the DUT's sum and
// carry, and checks them against a^b and a&b. Repeats the sweep NUM_PASSES
// times per run and reports the result.
//
// Ports:
//   clk        in   rising-edge system clock
//   rst        in   asynchronous active-high reset
//   start      in   single-cycle run request (accepted in IDLE or DONE)
//   dut_a      out  registered DUT input a
//   dut_b      out  registered DUT input b
//   dut_s      in   DUT sum output (same clock domain)
//   dut_c      in   DUT carry output (same clock domain)
//   busy       out  high while a run is in progress
//   done       out  high once a run completes, held until the next start
//   pass       out  valid while done; 1 when no mismatch was seen
//   err_count  out  saturating mismatch counter
//   fail_valid out  set on the first mismatch of a run
//   fail_vec   out  {a,b} of the first mismatching vector
module half_adder_bist #(
  parameter int SETTLE_CYCLES = 4,
  parameter int NUM_PASSES    = 16,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_s,
  input  logic             dut_c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [1:0]       fail_vec
);

  localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PC_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [SC_W-1:0]  SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [PC_W-1:0]  LAST_PASS   = PC_W'(NUM_PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q;
  logic [1:0]       vec_q;
  logic [PC_W-1:0]  pass_cnt_q;
  logic [SC_W-1:0]  settle_q;
  logic             dut_a_q;
  logic             dut_b_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_q;
  logic             fail_valid_q;
  logic [1:0]       fail_vec_q;

  logic             mismatch;
  logic [ERR_W-1:0] err_d;

  // Reference check of the sampled DUT outputs and the saturating error increment.
  always_comb begin
    mismatch = 1'b0;
    err_d    = err_q;
    mismatch = (dut_s != (dut_a_q ^ dut_b_q)) || (dut_c != (dut_a_q & dut_b_q));
    if (mismatch && (err_q != ERR_MAX)) begin
      err_d = err_q + {{(ERR_W-1){1'b0}}, 1'b1};
    end else begin
      err_d = err_q;
    end
  end

  // Test sequencer: vector/pass/settle counters and all registered status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      vec_q        <= 2'd0;
      pass_cnt_q   <= '0;
      settle_q     <= '0;
      dut_a_q      <= 1'b0;
      dut_b_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= 2'd0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            vec_q        <= 2'd0;
            pass_cnt_q   <= '0;
            busy_q       <= 1'b1;
            state_q      <= S_APPLY;
          end else begin
            state_q <= state_q;
          end
        end
        S_APPLY: begin
          {dut_a_q, dut_b_q} <= vec_q;
          settle_q           <= SETTLE_LOAD;
          state_q            <= S_SETTLE;
        end
        S_SETTLE: begin
          // Counter is loaded with SETTLE_CYCLES-1, so the state lasts SETTLE_CYCLES cycles.
          if (settle_q == '0) begin
            state_q <= S_CHECK;
          end else begin
            settle_q <= settle_q - {{(SC_W-1){1'b0}}, 1'b1};
          end
        end
        S_CHECK: begin
          err_q <= err_d;
          if (mismatch && !fail_valid_q) begin
            fail_valid_q <= 1'b1;
            fail_vec_q   <= {dut_a_q, dut_b_q};
          end
          if ((vec_q == 2'd3) && (pass_cnt_q == LAST_PASS)) begin
            // pass uses err_d so the final check of the run is included.
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
            state_q <= S_DONE;
          end else begin
            vec_q <= vec_q + 2'd1;
            if (vec_q == 2'd3) begin
              pass_cnt_q <= pass_cnt_q + {{(PC_W-1){1'b0}}, 1'b1};
            end
            state_q <= S_APPLY;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dut_a      = dut_a_q;
  assign dut_b      = dut_b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_half_adder_bist.sv
module tb_half_adder_bist;

  logic       clk;
  logic       rst;
  logic       start1;
  logic       start2;
  int         fault1;

  logic       a1, b1, s1, c1, busy1, done1, pass1, fv1;
  logic [7:0] err1;
  logic [1:0] vec1;
  logic       a2, b2, s2, c2, busy2, done2, pass2, fv2;
  logic [1:0] err2;
  logic [1:0] vec2;

  int checks;
  int errors;
  int n;

  // Main instance: SETTLE_CYCLES=4, NUM_PASSES=2, ERR_W=8, selectable fault.
  half_adder_bist #(.SETTLE_CYCLES(4), .NUM_PASSES(2), .ERR_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .dut_a(a1), .dut_b(b1), .dut_s(s1), .dut_c(c1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .fail_vec(vec1)
  );

  // Saturation instance: ERR_W=2, NUM_PASSES=4, DUT with inverted sum.
  half_adder_bist #(.SETTLE_CYCLES(4), .NUM_PASSES(4), .ERR_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .dut_a(a2), .dut_b(b2), .dut_s(s2), .dut_c(c2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_valid(fv2), .fail_vec(vec2)
  );

  // Behavioural half adder models: 0 good, 1 carry stuck-at-0, 2 s/c swapped.
  always_comb begin
    s1 = a1 ^ b1;
    c1 = a1 & b1;
    case (fault1)
      1: begin s1 = a1 ^ b1; c1 = 1'b0;    end
      2: begin s1 = a1 & b1; c1 = a1 ^ b1; end
      default: begin s1 = a1 ^ b1; c1 = a1 & b1; end
    endcase
  end

  assign s2 = ~(a2 ^ b2);
  assign c2 = a2 & b2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start1, count negedges with busy1 high; optionally pulse start mid-run.
  task automatic run1(input bit inject, output int cycles);
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    cycles = 0;
    while (busy1 === 1'b1 && cycles < 300) begin
      cycles++;
      @(negedge clk);
      start1 = (inject && (cycles == 5 || cycles == 20 || cycles == 47)) ? 1'b1 : 1'b0;
    end
    start1 = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    fault1 = 0;
    start1 = 1'b0;
    start2 = 1'b0;
    rst    = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy",  {31'd0, busy1}, 32'd0);
    chk("reset_done",  {31'd0, done1}, 32'd0);
    chk("reset_ab",    {30'd0, a1, b1}, 32'd0);
    chk("reset_err",   {24'd0, err1}, 32'd0);
    chk("reset_fv",    {31'd0, fv1}, 32'd0);
    @(negedge clk) rst = 1'b0;

    // Clean run.
    run1(1'b0, n);
    chk("good_busy_len", n, 32'd48);
    chk("good_done",  {31'd0, done1}, 32'd1);
    chk("good_pass",  {31'd0, pass1}, 32'd1);
    chk("good_err",   {24'd0, err1}, 32'd0);
    chk("good_fv",    {31'd0, fv1}, 32'd0);
    chk("good_ab_hold", {30'd0, a1, b1}, 32'd3);

    // Carry stuck-at-0: fails only at 11, once per pass.
    fault1 = 1;
    run1(1'b0, n);
    chk("c0_err",  {24'd0, err1}, 32'd2);
    chk("c0_vec",  {30'd0, vec1}, 32'd3);
    chk("c0_fv",   {31'd0, fv1}, 32'd1);
    chk("c0_pass", {31'd0, pass1}, 32'd0);
    chk("c0_done", {31'd0, done1}, 32'd1);

    // Swapped outputs: fails at 01, 10, 11.
    fault1 = 2;
    run1(1'b0, n);
    chk("swap_err",  {24'd0, err1}, 32'd6);
    chk("swap_vec",  {30'd0, vec1}, 32'd1);
    chk("swap_pass", {31'd0, pass1}, 32'd0);

    // Restart from DONE with a good DUT clears status at acceptance.
    fault1 = 0;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    chk("restart_err",  {24'd0, err1}, 32'd0);
    chk("restart_fv",   {31'd0, fv1}, 32'd0);
    chk("restart_done", {31'd0, done1}, 32'd0);
    chk("restart_busy", {31'd0, busy1}, 32'd1);
    // Abort during the second SETTLE (vector 01 on the pins).
    repeat (8) @(negedge clk);
    chk("abort_pre_b", {30'd0, a1, b1}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy1}, 32'd0);
    chk("abort_ab",   {30'd0, a1, b1}, 32'd0);
    chk("abort_err",  {24'd0, err1}, 32'd0);
    chk("abort_done", {31'd0, done1}, 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_stays", {31'd0, busy1}, 32'd0);

    // Start pulses while busy are ignored.
    run1(1'b1, n);
    chk("ign_busy_len", n, 32'd48);
    chk("ign_pass", {31'd0, pass1}, 32'd1);
    chk("ign_err",  {24'd0, err1}, 32'd0);

    // Saturating counter instance.
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    n = 0;
    while (busy2 === 1'b1 && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk("sat_busy_len", n, 32'd96);
    chk("sat_err",  {30'd0, err2}, 32'd3);
    chk("sat_vec",  {30'd0, vec2}, 32'd0);
    chk("sat_fv",   {31'd0, fv2}, 32'd1);
    chk("sat_pass", {31'd0, pass2}, 32'd0);
    chk("sat_done", {31'd0, done2}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/half_adder_bist.md
Name: half_adder_bist

Overview:
- On-board built-in self-test engine that acts as the stimulus and checking end of the half-adder interface on the SP605 board.
- Drives a, b into a combinational half-adder DUT and samples its s, c outputs.
- Compares the sampled outputs against s = a^b, c = a&b, and counts mismatches.
- Reports pass/fail status, intended for LEDs or a debug register.

Parameters:
- SETTLE_CYCLES, 4: cycles a vector is held on the DUT pins before sampling; legal range is 1 or more.
- NUM_PASSES, 16: number of full 4-vector sweeps per run; legal range is 1 or more.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  system clock; every register is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a run.
- dut_a  output  1  registered DUT input a.
- dut_b  output  1  registered DUT input b.
- dut_s  input  1  DUT sum output, same clock domain, no synchroniser.
- dut_c  input  1  DUT carry output, same clock domain, no synchroniser.
- busy  output  1  high while a run is in progress.
- done  output  1  high once a run completes; held until the next accepted start.
- pass  output  1  valid while done; 1 when err_count == 0.
- err_count  output  ERR_W  number of mismatching checks; saturates at 2^ERR_W-1.
- fail_valid  output  1  set on the first mismatch of a run.
- fail_vec  output  2  {a,b} of the first mismatching vector; valid when fail_valid is set.

Behaviour:
- Reset (async, rst=1): state=IDLE; dut_a, dut_b, busy, done, pass, err_count, fail_valid, fail_vec all 0; vector and pass counters 0.
- States are IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE / DONE:
  - start=1 clears err_count, fail_valid, fail_vec, done, pass, vec=0, pass_cnt=0, then goes to APPLY.
  - start=0 holds the state.
- APPLY, one cycle:
  - {dut_a,dut_b} <= vec, visible from the next cycle.
  - Load the settle counter, then go to SETTLE.
- SETTLE: stays for exactly SETTLE_CYCLES cycles with the vector on the pins, then goes to CHECK.
- CHECK, one cycle:
  - Sample dut_s and dut_c; expected values are exp_s = dut_a ^ dut_b and exp_c = dut_a & dut_b.
  - Any mismatch increments err_count by 1; no increment when already at the maximum.
  - On a mismatch with fail_valid=0: fail_vec <= {dut_a,dut_b}, fail_valid <= 1.
  - If vec==3 and pass_cnt==NUM_PASSES-1: go to DONE.
  - Otherwise vec <= vec+1 (wraps 3→0); on the wrap, pass_cnt increments; go to APPLY.
- Vector order is 00, 01, 10, 11, given as {a,b}.
- Per-vector cost is SETTLE_CYCLES+2 cycles. A run is 4*NUM_PASSES*(SETTLE_CYCLES+2) cycles from the first APPLY to the DONE entry.
- busy=1 in APPLY, SETTLE and CHECK; 0 otherwise.
- On DONE entry: done=1, pass=(final err_count==0). Both hold until the next accepted start.
- dut_a and dut_b keep their last value (11) in DONE; they return to 0 only on reset.
- start while busy=1 is ignored and has no effect on counters.
- start held high across DONE entry: a new run starts on the first DONE cycle in which start=1.
- rst asserted mid-run aborts immediately and returns to the reset values; no partial status is retained.
- Saturating counter: when err_count == 2^ERR_W-1, further mismatches leave it unchanged. fail_* still behaves as above.

Test Plan:
- Correct DUT, SETTLE_CYCLES=4, NUM_PASSES=2, one start pulse:
  - busy high for 48 cycles, then done=1, pass=1, err_count=0, fail_valid=0.
- Carry stuck-at-0 DUT, NUM_PASSES=2:
  - err_count=2, fail_vec=2'b11, fail_valid=1, pass=0.
- s/c swapped DUT, NUM_PASSES=2:
  - mismatches at 01, 10 and 11 in each pass.
  - err_count=6, fail_vec=2'b01, pass=0.
- Inverted-s DUT, ERR_W=2, NUM_PASSES=4:
  - 16 mismatches; err_count saturates at 3; fail_vec=2'b00.
- Reset and start handling, correct DUT:
  - rst pulse during the second SETTLE of pass 0: all outputs 0 and state IDLE within the same cycle (async).
  - start pulses while busy are ignored.
  - Restart from DONE clears the previous err_count and fail_valid, and a clean run gives pass=1.
